// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QCNT_W = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Branch targets are word addresses; low bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ack bus between fetch (master) and memory (slave).
interface fetch_if;
  import fetch_pkg::*;

  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemAck;
  logic [XLEN-1:0] IMemData;

  modport master (output IMemReq, IMemAddr, input IMemAck, IMemData);
  modport slave  (input IMemReq, IMemAddr, output IMemAck, IMemData);

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO of fetched words; head always lives in one register.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      wdata,
  output logic [QCNT_W-1:0] count_next_c,
  output logic              valid,
  output fetch_entry_t      head
);

  logic [QCNT_W-1:0] count;
  fetch_entry_t      tail;
  logic              pop_ok;

  assign pop_ok = pop && valid;

  // Occupancy after this edge; flush wins over any push/pop.
  always_comb begin
    count_next_c = count;
    if (flush) begin
      count_next_c = '0;
    end else begin
      count_next_c = count + QCNT_W'(push) - QCNT_W'(pop_ok);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count_next_c;
      valid <= (count_next_c != '0);
      if (!flush) begin
        if (pop_ok && push) begin
          if (count == QCNT_W'(2)) begin
            head <= tail;
            tail <= wdata;
          end else begin
            head <= wdata;
          end
        end else if (pop_ok) begin
          head <= tail;
        end else if (push) begin
          if (count == '0) begin
            head <= wdata;
          end else begin
            tail <= wdata;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the single-outstanding imem handshake,
// buffers returned words for decode and handles execute-stage redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Stall,
  input  logic            Taken,
  input  logic [XLEN-1:0] Target,
  fetch_if.master         imem,
  output logic            InstrValid,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] InstrPC
);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   redirect_q, redirect_d;
  logic              req_q, req_d;
  logic              push_c, pop_c, flush_c, room_c;
  logic [XLEN-1:0]   target_c;
  logic [QCNT_W-1:0] count_next_c;
  fetch_entry_t      head;

  assign target_c = word_align(Target);
  assign pop_c    = InstrValid && !Stall;
  assign flush_c  = Taken;
  // Only a correct-path ack in FETCH delivers a word; DRAIN acks are discarded.
  assign push_c   = (state_q == FETCH) && imem.IMemAck && !Taken;
  assign room_c   = count_next_c < QCNT_W'(DEPTH);

  fetch_queue u_queue (
    .Clock        (Clock),
    .nReset       (nReset),
    .push         (push_c),
    .pop          (pop_c),
    .flush        (flush_c),
    .wdata        ('{pc: pc_q, instr: imem.IMemData}),
    .count_next_c (count_next_c),
    .valid        (InstrValid),
    .head         (head)
  );

  // Next-state, next-PC and request decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    req_d      = 1'b0;
    case (state_q)
      HOLD: begin
        if (Taken) begin
          pc_d    = target_c;
          state_d = FETCH;
        end else if (room_c) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem.IMemAck) begin
          if (Taken) begin
            pc_d = target_c;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = room_c ? FETCH : HOLD;
          end
        end else if (Taken) begin
          redirect_d = target_c;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // The wrong-path request must complete before the target can be issued.
        if (imem.IMemAck) begin
          pc_d    = Taken ? target_c : redirect_q;
          state_d = FETCH;
        end else if (Taken) begin
          redirect_d = target_c;
        end
      end
      default: state_d = HOLD;
    endcase
    req_d = (state_d != HOLD);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= HOLD;
      pc_q       <= RESET_PC;
      redirect_q <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      req_q      <= req_d;
    end
  end

  assign imem.IMemReq  = req_q;
  assign imem.IMemAddr = pc_q;
  assign Instr         = head.instr;
  assign InstrPC       = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  logic        Clock  = 1'b0;
  logic        nReset = 1'b1;
  logic        Stall  = 1'b0;
  logic        Taken  = 1'b0;
  logic [31:0] Target = 32'h0;
  logic        InstrValid;
  logic [31:0] Instr, InstrPC;

  int unsigned ack_lat  = 0;
  int unsigned wait_cnt = 0;
  int          n_cmp    = 0;
  int          n_fail   = 0;

  fetch_if bus ();

  fetch_unit dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Stall      (Stall),
    .Taken      (Taken),
    .Target     (Target),
    .imem       (bus),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC)
  );

  always #5 Clock = ~Clock;

  // Memory: acks once a request has waited ack_lat cycles; data is a fixed function of the address.
  assign bus.IMemAck  = bus.IMemReq && (wait_cnt >= ack_lat);
  assign bus.IMemData = bus.IMemAddr ^ 32'hDEAD_BEEF;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset)          wait_cnt <= 0;
    else if (bus.IMemAck) wait_cnt <= 0;
    else if (bus.IMemReq) wait_cnt <= wait_cnt + 1;
  end

  // Reference model: a FIFO of {pc, word}, the fetch address, and a pending-redirect slot.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic        m_req   = 1'b0;
  logic        m_drain = 1'b0;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_redir = 32'h0;

  task automatic model_step();
    logic [31:0] t;
    bit          pop;
    bit          ack;
    t   = {Target[31:2], 2'b00};
    pop = (mq.size() > 0) && !Stall;
    ack = bus.IMemAck;
    if (!nReset) begin
      mq.delete();
      m_req = 1'b0; m_drain = 1'b0; m_addr = 32'h0; m_redir = 32'h0;
    end else if (m_req && ack) begin
      if (m_drain) begin
        mq.delete();
        m_addr  = Taken ? t : m_redir;
        m_drain = 1'b0;
      end else if (Taken) begin
        mq.delete();
        m_addr = t;
      end else begin
        if (pop) void'(mq.pop_front());
        mq.push_back('{m_addr, m_addr ^ 32'hDEAD_BEEF});
        m_addr = m_addr + 32'd4;
      end
      m_req = (mq.size() < 2);
    end else if (m_req) begin
      if (Taken) begin
        mq.delete();
        m_redir = t;
        m_drain = 1'b1;
      end else if (pop) begin
        void'(mq.pop_front());
      end
    end else begin
      if (Taken) begin
        mq.delete();
        m_addr = t;
        m_req  = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        m_req = (mq.size() < 2);
      end
    end
  endtask

  always @(posedge Clock or negedge nReset) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clock) begin
    if (nReset) begin
      check("m_req",   32'(bus.IMemReq), 32'(m_req));
      check("m_addr",  bus.IMemAddr, m_addr);
      check("m_valid", 32'(InstrValid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("m_instr", Instr, mq[0].instr);
        check("m_pc",    InstrPC, mq[0].pc);
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(bus.IMemReq), 32'h0);
    check({tag, "_addr"},  bus.IMemAddr, 32'h0);
    check({tag, "_valid"}, 32'(InstrValid), 32'h0);
    check({tag, "_instr"}, Instr, 32'h0);
    check({tag, "_pc"},    InstrPC, 32'h0);
  endtask

  initial begin
    #1 nReset = 1'b0;
    #2 check_reset_vals("rst");
    tick(); nReset = 1'b1;
    tick(); check("first_req", 32'(bus.IMemReq), 32'h1); check("first_addr", bus.IMemAddr, 32'h0);
    tick(); check("pc0", InstrPC, 32'h0); check("instr0", Instr, 32'hDEAD_BEEF);
            check("addr4", bus.IMemAddr, 32'h4);
    tick(); check("pc4", InstrPC, 32'h4); check("instr4", Instr, 32'hDEAD_BEEB);
    tick(); check("pc8", InstrPC, 32'h8); check("addrC", bus.IMemAddr, 32'hC);
            Stall = 1'b1;
    tick(); check("stall_hold_req", 32'(bus.IMemReq), 32'h0);
    tick();
    tick(); check("stall_frozen_pc", InstrPC, 32'h8); check("stall_frozen_instr", Instr, 32'hDEAD_BEE7);
            Stall = 1'b0;
    tick(); check("resume_pc", InstrPC, 32'hC); check("resume_addr", bus.IMemAddr, 32'h10);
    tick(); check("resume_pc2", InstrPC, 32'h10);
            Taken = 1'b1; Target = 32'h1000;
    tick(); Taken = 1'b0;
            check("redir_valid", 32'(InstrValid), 32'h0); check("redir_addr", bus.IMemAddr, 32'h1000);
    tick(); check("redir_pc", InstrPC, 32'h1000); check("redir_instr", Instr, 32'hDEAD_AEEF);
            Taken = 1'b1; Target = 32'h40;
    tick(); check("to40_addr", bus.IMemAddr, 32'h40);
            Target = 32'h2000; ack_lat = 3;
    tick(); Taken = 1'b0;
            check("drain_addr_a", bus.IMemAddr, 32'h40); check("drain_req", 32'(bus.IMemReq), 32'h1);
    tick(); check("drain_addr_b", bus.IMemAddr, 32'h40);
            Taken = 1'b1; Target = 32'h3000;
    tick(); Taken = 1'b0; check("drain_addr_c", bus.IMemAddr, 32'h40);
    tick(); check("restart_addr", bus.IMemAddr, 32'h3000); check("drain_valid", 32'(InstrValid), 32'h0);
            ack_lat = 0;
    tick(); check("restart_pc", InstrPC, 32'h3000); check("restart_instr", Instr, 32'hDEAD_8EEF);
            Taken = 1'b1; Target = 32'hFFFF_FFFF;
    tick(); Taken = 1'b0; check("top_addr", bus.IMemAddr, 32'hFFFF_FFFC);
    tick(); check("wrap_addr", bus.IMemAddr, 32'h0); check("wrap_pc", InstrPC, 32'hFFFF_FFFC);
            check("wrap_instr", Instr, 32'h2152_4113);
            Stall = 1'b1;
    tick(); check("full_hold", 32'(bus.IMemReq), 32'h0);
            Stall = 1'b0; ack_lat = 5;
    tick(); check("pend_req", 32'(bus.IMemReq), 32'h1); check("pend_addr", bus.IMemAddr, 32'h4);
            Stall = 1'b1;
    tick(); #2 nReset = 1'b0;
    #1 check_reset_vals("midrst");
    tick(); nReset = 1'b1; Stall = 1'b0; ack_lat = 0;
    tick(); check("rst2_req", 32'(bus.IMemReq), 32'h1); check("rst2_addr", bus.IMemAddr, 32'h0);
    tick(); check("rst2_pc", InstrPC, 32'h0);
    // Mixed traffic checked only by the model.
    for (int i = 0; i < 60; i++) begin
      Stall   = ((i % 5) == 3);
      Taken   = ((i % 13) == 7);
      Target  = 32'h500 + 32'(i) * 32'd16 + 32'(i % 4);
      ack_lat = (i / 10) % 3;
      tick();
    end
    Taken = 1'b0; Stall = 1'b0;
    repeat (6) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
